mdu_iter: RTL
=============

# mdu_iter

Iterative RV32M multiply/divide unit on the execute side of the core, directly downstream of the register file read ports. It consumes rs1/rs2 operands and returns a 32-bit result with a ready-made register-file write request. Multiplies use radix-2 shift-add; divides use restoring division. Both run one bit per cycle, so area stays small and a fixed latency is acceptable.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; accepted only on an edge where busy=0
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rd  in  5  destination register, carried through to wb_addr
- op_a  in  32  rs1 value (regfile readdata1)
- op_b  in  32  rs2 value (regfile readdata2)
- kill  in  1  abort the in-flight op (pipeline flush)
- busy  out  1  op in progress; start ignored while high
- done  out  1  one-cycle pulse; result valid
- result  out  32  final value, held until the next done
- wb_we  out  1  done & (wb_addr != 0); drives the regfile write enable
- wb_addr  out  5  captured rd
- wb_data  out  32  equals result
- illegal  out  1  one-cycle pulse with done for an unsupported op (see Configuration)

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: on start=1 & kill=0, capture funct3, rd, op_a, op_b.
  - Divisor 0 or signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) → DONE (fast path).
  - Otherwise → CALC, count=0.
- Operand conditioning:
  - Signed operands (MULH: both; MULHSU: op_a only; DIV/REM: both) are converted to magnitudes.
  - neg_res is recorded at capture:
    - MUL*: sign_a XOR sign_b.
    - DIV: sign_a XOR sign_b.
    - REM: sign_a.
  - MUL takes the low word and is sign-agnostic; it runs as unsigned.
- CALC: one iteration per cycle; 64-bit product or remainder/quotient shift register. After count=31 → FIXUP.
- FIXUP: two's-complement negate if neg_res. Select low word (MUL), high word (MULH/HSU/HU), quotient or remainder. → DONE.
- DONE: done=1 for exactly one cycle, busy=0. Returns to IDLE, or accepts a new start in the same cycle (back-to-back).
- Fast-path results:
  - DIV/DIVU by 0 → 0xFFFFFFFF.
  - REM/REMU by 0 → op_a.
  - Overflow DIV → 0x80000000.
  - Overflow REM → 0.
- kill=1 on any edge: → IDLE, no done, no wb_we. kill beats a simultaneous start; that start is dropped.
- A start while busy=1 is ignored; no queuing.
- rst_n=0 mid-op: op discarded, same as kill.

## Timing
- Reset values: busy=0, done=0, result=0, wb_we=0, wb_addr=0, wb_data=0, illegal=0; state IDLE.
- Accepting edge N: busy=1 from cycle N+1.
- Normal ops: CALC on edges N+1..N+32, FIXUP edge N+33. done=1 and busy=0 in the cycle after edge N+33, so latency is 34 cycles.
- Fast path: done in the cycle after edge N+1, so latency is 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Throughput: one op per 34 cycles, with back-to-back start accepted in the DONE cycle.

## Configuration
- MDU_DIV_EN defined: full RV32M support.
- MDU_DIV_EN undefined:
  - Divider datapath and the overflow/zero checks are compiled out.
  - funct3[2]=1 takes the fast path: result=0, done=1 with illegal=1, wb_we=0.
  - Multiply ops are unchanged.
  - illegal is tied 0 when the macro is defined.

## Test plan
- MUL, op_a=7, op_b=0xFFFFFFFD (-3), rd=5 → after 34 cycles: done=1, result=0xFFFFFFEB, wb_we=1, wb_addr=5; busy high for exactly 33 cycles.
- High-word multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Issue back-to-back, with the second start asserted in the first DONE cycle.
- Fast path, done 2 cycles after start:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Abort and edge cases:
  - kill on cycle 10 of a MUL → no done; busy=0 next cycle; a new MULHU 3×4 → result 0.
  - rd=0 → done=1, wb_we=0.
  - rst_n=0 mid-DIV → all outputs 0 next cycle.
- Build without MDU_DIV_EN: DIV 9/3 → done=1, illegal=1, result=0, wb_we=0, 2-cycle latency; MUL 9×3 → 27.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: 34 cycles for normal ops, 2 cycles on the fast path.
// No queuing; start is taken only while busy=0; kill and rst_n drop the op.
//
// Ports: clk, rst_n (sync, active-low); start/funct3/rd/op_a/op_b request;
//        kill flush; busy, done pulse, result; wb_we/wb_addr/wb_data regfile write;
//        illegal pulse (unsupported op).
// Build option: define MDU_DIV_EN for DIV/DIVU/REM/REMU. Without it the divider is
// compiled out and divide ops finish on the fast path with illegal=1.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [4:0]       rd,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             kill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             wb_we,
   output logic [4:0]       wb_addr,
   output logic [WIDTH-1:0] wb_data,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIXUP,
      S_DONE
   } state_t;

   state_t               state;
   logic [2:0]           fn_q;
   logic [4:0]           rd_q;
   logic [WIDTH-1:0]     b_q;       // multiplicand or divisor magnitude
   logic                 neg_q;
   logic                 fast_q;
   logic [CW-1:0]        count;
   // Multiply: {partial product, multiplier}. Divide: {remainder, quotient/dividend}.
   logic [2*WIDTH-1:0]   acc;

   // ---------------- capture-time operand conditioning ----------------
   logic                 a_signed, b_signed, sa, sb;
   logic [WIDTH-1:0]     cap_a, cap_b;
   logic                 cap_neg, cap_fast;
`ifdef MDU_DIV_EN
   logic [WIDTH-1:0]     cap_fast_res;
   logic [WIDTH-1:0]     fast_res_q;
`endif

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (funct3)
         3'b001: begin a_signed = 1'b1; b_signed = 1'b1; end
         3'b010: a_signed = 1'b1;
`ifdef MDU_DIV_EN
         3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
`endif
         default: ;
      endcase
      sa      = a_signed & op_a[WIDTH-1];
      sb      = b_signed & op_b[WIDTH-1];
      cap_a   = sa ? -op_a : op_a;
      cap_b   = sb ? -op_b : op_b;
      // Remainder takes the dividend's sign; everything else the XOR.
      cap_neg = (funct3 == 3'b110) ? sa : (sa ^ sb);
      cap_fast = 1'b0;
`ifdef MDU_DIV_EN
      cap_fast_res = '0;
      if (funct3[2]) begin
         if (op_b == '0) begin
            cap_fast     = 1'b1;
            cap_fast_res = funct3[1] ? op_a : '1;
         end else if (!funct3[0] && op_a == {1'b1, {(WIDTH-1){1'b0}}} && op_b == '1) begin
            // Signed overflow: quotient is the dividend, remainder is zero.
            cap_fast     = 1'b1;
            cap_fast_res = funct3[1] ? '0 : op_a;
         end
      end
`else
      if (funct3[2]) cap_fast = 1'b1;
`endif
   end

   // ---------------- one iteration ----------------
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   acc_next;
`ifdef MDU_DIV_EN
   logic [WIDTH:0]       div_part, div_diff;
`endif

   always_comb begin
      // Add multiplicand into the high half when the current multiplier bit is set,
      // then shift right; the carry becomes the new top bit.
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_q : {WIDTH{1'b0}})};
      acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
      // Shift in the next dividend bit and try to subtract the divisor.
      div_part = acc[2*WIDTH-1:WIDTH-1];
      div_diff = div_part - {1'b0, b_q};
      if (fn_q[2]) begin
         if (!div_diff[WIDTH])
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
`endif
   end

   // ---------------- sign fixup and word select ----------------
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     fix_res;
`ifdef MDU_DIV_EN
   logic [WIDTH-1:0]     div_word;
`endif

   always_comb begin
      // High-word products need the full 64-bit negate, not a negate of the word.
      prod_fix = neg_q ? -acc : acc;
      fix_res  = (fn_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
`ifdef MDU_DIV_EN
      div_word = fn_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      if (fn_q[2]) fix_res = neg_q ? -div_word : div_word;
      if (fast_q)  fix_res = fast_res_q;
`else
      if (fast_q)  fix_res = '0;
`endif
   end

   // ---------------- control ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         wb_we   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         illegal <= 1'b0;
         fn_q    <= '0;
         rd_q    <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         fast_q  <= 1'b0;
         count   <= '0;
         acc     <= '0;
`ifdef MDU_DIV_EN
         fast_res_q <= '0;
`endif
      end else begin
         done    <= 1'b0;
         wb_we   <= 1'b0;
         illegal <= 1'b0;
         if (kill) begin
            // Flush wins over everything, including a same-edge start.
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     fn_q   <= funct3;
                     rd_q   <= rd;
                     b_q    <= cap_b;
                     neg_q  <= cap_neg;
                     fast_q <= cap_fast;
                     acc    <= {{WIDTH{1'b0}}, cap_a};
                     count  <= '0;
                     busy   <= 1'b1;
`ifdef MDU_DIV_EN
                     fast_res_q <= cap_fast_res;
`endif
                     // Fast path skips iteration but still spends one cycle in
                     // FIXUP so the result leaves through the same registers.
                     state  <= cap_fast ? S_FIXUP : S_CALC;
                  end else begin
                     state  <= S_IDLE;
                  end
               end
               S_CALC: begin
                  acc   <= acc_next;
                  count <= count + 1'b1;
                  if (count == LAST) state <= S_FIXUP;
               end
               S_FIXUP: begin
                  result  <= fix_res;
                  wb_data <= fix_res;
                  wb_addr <= rd_q;
                  done    <= 1'b1;
                  busy    <= 1'b0;
`ifdef MDU_DIV_EN
                  wb_we   <= (rd_q != '0);
`else
                  wb_we   <= (rd_q != '0) & ~fn_q[2];
                  illegal <= fn_q[2];
`endif
                  state   <= S_DONE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
